// File: rtl/neo_pixel_tx.sv
// ---------------------------------------------------------------------------
// neo_pixel_tx
//
// Collects a byte stream into GRB pixels and stores one frame of NUM_LEDS
// pixels. When the frame is full, it sends the frame out on a single-wire
// WS2812 NRZ line, then holds the line low for the latch period.
//
// Ports:
//   clk         system clock (50 MHz)
//   rst         asynchronous reset, active high
//   byte_in     received byte
//   byte_valid  one-cycle strobe qualifying byte_in
//   dout        WS2812 serial data line (registered)
//   busy        high while sending or latching
//   frame_done  one-cycle pulse in the last latch cycle
//   overrun     sticky flag: a byte arrived while the block was busy
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_LOAD  | dout low; bytes fill the pixel buffer, G then R then B
// ST_SEND  | frame goes out pixel 0 first, MSB first, T_BIT cycles per bit
// ST_LATCH | dout low for T_RST cycles; frame_done in the final cycle
// ---------------------------------------------------------------------------
module neo_pixel_tx #(
    parameter int NUM_LEDS = 8,
    parameter int T_BIT    = 63,
    parameter int T0H      = 20,
    parameter int T1H      = 40,
    parameter int T_RST    = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       dout,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int PW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CMAX = (T_RST > T_BIT) ? T_RST : T_BIT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [PW-1:0] PIX_LAST = PW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(T_BIT - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(T_RST - 1);
    localparam logic [CW-1:0] TH0      = CW'(T0H);
    localparam logic [CW-1:0] TH1      = CW'(T1H);

    // Depth rounded up to a power of two so the index width matches exactly.
    logic [23:0] pix_mem [2**PW];

    state_t        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [4:0]    bit_q, bit_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          full_q, full_d;
    logic          dout_q, dout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;
    logic          wr_en;
    logic          next_bit;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pix_d      = pix_q;
        bit_d      = bit_q;
        cyc_d      = cyc_q;
        full_d     = full_q;
        wr_en      = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // full_q delays the start of SEND by one clock after the
                // completing byte has been written.
                if (full_q) begin
                    state_d = ST_SEND;
                    pix_d   = '0;
                    bit_d   = 5'd23;
                    cyc_d   = '0;
                    full_d  = 1'b0;
                end else if (byte_valid) begin
                    wr_en = 1'b1;
                    if (byte_cnt_q == 2'd2) begin
                        byte_cnt_d = 2'd0;
                        if (pix_q == PIX_LAST) begin
                            full_d = 1'b1;
                        end else begin
                            pix_d = pix_q + 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            ST_SEND: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d = '0;
                    if (bit_q == 5'd0) begin
                        if (pix_q == PIX_LAST) begin
                            state_d = ST_LATCH;
                        end else begin
                            pix_d = pix_q + 1'b1;
                            bit_d = 5'd23;
                        end
                    end else begin
                        bit_d = bit_q - 5'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (cyc_q == RST_LAST) begin
                    state_d    = ST_LOAD;
                    cyc_d      = '0;
                    byte_cnt_d = 2'd0;
                    pix_d      = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Outputs are computed from next-state values so the registered
        // line lines up with the cycle counter of the bit being sent.
        next_bit = pix_mem[pix_d][bit_d];
        dout_d   = (state_d == ST_SEND) && (cyc_d < (next_bit ? TH1 : TH0));
        busy_d   = (state_d != ST_LOAD);
        done_d   = (state_d == ST_LATCH) && (cyc_d == RST_LAST);
        ovr_d    = ovr_q | (byte_valid & ((state_q != ST_LOAD) | full_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            byte_cnt_q <= 2'd0;
            pix_q      <= '0;
            bit_q      <= 5'd0;
            cyc_q      <= '0;
            full_q     <= 1'b0;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pix_q      <= pix_d;
            bit_q      <= bit_d;
            cyc_q      <= cyc_d;
            full_q     <= full_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

    // Pixel buffer keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (byte_cnt_q)
                2'd0:    pix_mem[pix_q][23:16] <= byte_in;
                2'd1:    pix_mem[pix_q][15:8]  <= byte_in;
                default: pix_mem[pix_q][7:0]   <= byte_in;
            endcase
        end
    end

    assign dout       = dout_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_neo_pixel_tx.sv
module tb_neo_pixel_tx;

    localparam int NL        = 2;
    localparam int TB_T_BIT  = 63;
    localparam int TB_T0H    = 20;
    localparam int TB_T1H    = 40;
    localparam int TB_T_RST  = 3000;
    localparam int NBYTES    = 3 * NL;
    localparam int NBITS     = 24 * NL;
    localparam int SEND_CYC  = NBITS * TB_T_BIT;
    localparam int FRAME_CYC = SEND_CYC + TB_T_RST;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       dout;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    int n_cmp    = 0;
    int n_bad    = 0;
    int fd_count = 0;
    int fd_base;

    logic [7:0] fb [NBYTES];
    logic       dsamp [SEND_CYC];

    neo_pixel_tx #(
        .NUM_LEDS (NL),
        .T_BIT    (TB_T_BIT),
        .T0H      (TB_T0H),
        .T1H      (TB_T1H),
        .T_RST    (TB_T_RST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic load_frame();
        for (int i = 0; i < NBYTES; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_byte(fb[i]);
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < NBYTES; i++) fb[i] = 8'($urandom);
    endtask

    // Expected line: the frame bytes in arrival order, MSB first, each bit a
    // T_BIT window whose first T1H/T0H cycles are high; then T_RST low cycles.
    task automatic run_frame(input int inj_a, input int inj_b);
        int   ones_latch = 0;
        int   busy_low   = 0;
        int   fd_early   = 0;
        logic fd_last    = 1'b0;
        check_val("busy_before_send", 64'(busy), 64'd0);
        @(negedge clk);
        check_val("busy_rise", 64'(busy), 64'd1);
        for (int j = 0; j < FRAME_CYC; j++) begin
            if (j > 0) @(negedge clk);
            if (j < SEND_CYC) dsamp[j] = dout;
            else if (dout !== 1'b0) ones_latch++;
            if (busy !== 1'b1) busy_low++;
            if (j < FRAME_CYC - 1) begin
                if (frame_done !== 1'b0) fd_early++;
            end else begin
                fd_last = frame_done;
            end
            byte_in    = 8'h55;
            byte_valid = (j == inj_a) || (j == inj_b);
        end
        byte_valid = 1'b0;
        for (int k = 0; k < NBITS; k++) begin
            logic        bv;
            int          th;
            logic [63:0] obs;
            logic [63:0] ex;
            bv  = fb[k / 8][7 - (k % 8)];
            th  = bv ? TB_T1H : TB_T0H;
            obs = '0;
            ex  = '0;
            for (int c = 0; c < TB_T_BIT; c++) begin
                obs[c] = dsamp[k * TB_T_BIT + c];
                ex[c]  = (c < th);
            end
            check_val($sformatf("bit%0d_window", k), obs, ex);
        end
        check_val("latch_dout_high_cycles", 64'(ones_latch), 64'd0);
        check_val("busy_low_cycles", 64'(busy_low), 64'd0);
        check_val("frame_done_early", 64'(fd_early), 64'd0);
        check_val("frame_done_last", 64'(fd_last), 64'd1);
        @(negedge clk);
        check_val("busy_after_latch", 64'(busy), 64'd0);
        check_val("frame_done_after", 64'(frame_done), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_dout", 64'(dout), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_frame_done", 64'(frame_done), 64'd0);
        check_val("rst_overrun", 64'(overrun), 64'd0);

        // Directed frame
        fb[0] = 8'hFF; fb[1] = 8'h00; fb[2] = 8'hAA;
        fb[3] = 8'h01; fb[4] = 8'h80; fb[5] = 8'h00;
        load_frame();
        run_frame(-1, -1);

        // Pixel 0x800001 plus a random second pixel
        fb[0] = 8'h80; fb[1] = 8'h00; fb[2] = 8'h01;
        fb[3] = 8'($urandom); fb[4] = 8'($urandom); fb[5] = 8'($urandom);
        load_frame();
        run_frame(-1, -1);

        // Overrun during SEND and LATCH; waveform must be unaffected
        rand_frame();
        load_frame();
        run_frame(1000, SEND_CYC + 1500);
        check_val("overrun_set", 64'(overrun), 64'd1);

        // Next frame loads from pixel 0 / byte G; overrun still sticky
        rand_frame();
        load_frame();
        run_frame(-1, -1);
        check_val("overrun_sticky", 64'(overrun), 64'd1);

        // Async reset in the middle of SEND
        rand_frame();
        load_frame();
        @(negedge clk);
        check_val("abort_busy_rise", 64'(busy), 64'd1);
        repeat (500) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check_val("abort_dout_async", 64'(dout), 64'd0);
        check_val("abort_busy_async", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("abort_overrun_cleared", 64'(overrun), 64'd0);
        check_val("abort_busy_after", 64'(busy), 64'd0);
        rand_frame();
        load_frame();
        run_frame(-1, -1);

        // Back-to-back frames
        fd_base = fd_count;
        rand_frame();
        load_frame();
        run_frame(-1, -1);
        rand_frame();
        load_frame();
        run_frame(-1, -1);
        check_val("frame_done_pulses", 64'(fd_count - fd_base), 64'd2);
        check_val("overrun_clear_end", 64'(overrun), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neo_pixel_tx.md
Name: neo_pixel_tx

Overview:
- Downstream consumer of the UART receiver's byte stream; drives the WS2812 ("NeoPixel") LED chain.
- Assembles incoming bytes into 24-bit GRB pixels and stores one full frame of NUM_LEDS pixels.
- Once the frame is complete, serialises it onto a single-wire NRZ output with WS2812 timing, then holds the latch/reset low period.
- System clock is 50 MHz, the same clock as the UART receiver.

Parameters:
- NUM_LEDS, 8, number of pixels per frame (range 1..256).
- T_BIT, 63, clock cycles per data bit (1.26 us at 50 MHz).
- T0H, 20, high cycles for a '0' bit (0.40 us).
- T1H, 40, high cycles for a '1' bit (0.80 us).
- T_RST, 3000, low cycles for the latch period after a frame (60 us).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- byte_in  input  8  received UART byte.
- byte_valid  input  1  one-cycle strobe; byte_in is valid in this cycle.
- dout  output  1  WS2812 serial data line.
- busy  output  1  high while in SEND or LATCH.
- frame_done  output  1  one-cycle pulse when LATCH ends.
- overrun  output  1  sticky flag: a byte arrived while busy.

Behaviour:
- Reset (async, active-high):
  - state=LOAD; dout=0, busy=0, frame_done=0, overrun=0.
  - Byte counter, pixel index, bit counter and cycle counter all cleared.
  - Pixel buffer contents are not cleared.
  - Reset mid-SEND aborts immediately; dout is 0 from reset assertion onward.
- Byte order per pixel: 1st byte=G, 2nd=R, 3rd=B. Pixel word = {G,R,B}, 24 bits.
- LOAD state:
  - dout=0, busy=0.
  - Each byte_valid writes byte_in into the current pixel slot at the current byte position.
  - Byte counter runs 0,1,2 and wraps to 0; on wrap the pixel index increments.
  - The byte that completes pixel NUM_LEDS-1 is written. On the next clock: state=SEND, busy=1, pixel index=0, bit index=23, cycle counter=0.
- SEND state:
  - Pixels go out in index order 0..NUM_LEDS-1; bits go MSB first (G7 first, B0 last).
  - Each bit lasts exactly T_BIT cycles.
  - dout=1 for cycle counter 0..TH-1 and dout=0 for TH..T_BIT-1, where TH=T1H if the bit is 1, else T0H.
  - Bits are back to back; there are no gap cycles between bits or pixels.
  - After the last bit of the last pixel completes: state=LATCH, cycle counter=0.
  - Total SEND duration is exactly NUM_LEDS*24*T_BIT cycles.
- LATCH state:
  - dout=0 for T_RST cycles.
  - In the final cycle: frame_done=1 for one cycle. On the next clock: state=LOAD, busy=0, byte and pixel counters=0.
- Bytes received while busy:
  - Any byte_valid during SEND or LATCH is dropped and sets overrun=1.
  - overrun stays set until rst.
  - The buffer is never modified while busy.
- byte_valid in the same cycle as the LOAD->SEND transition cannot occur, because the transition follows the completing byte by one clock.
- Partial frames: the block stays in LOAD indefinitely, with no timeout.
- A new frame overwrites the buffer pixel by pixel starting at index 0.
- All outputs are registered; dout has no combinational path from the inputs.

Test Plan:
- Reset defaults: assert rst for 3 cycles, then release -> dout=0, busy=0, frame_done=0, overrun=0, state LOAD.
- Single frame: NUM_LEDS=2; bytes 0xFF,0x00,0xAA,0x01,0x80,0x00 ->
  - busy rises 1 cycle after the 6th byte.
  - First 8 bits are 40-cycle highs; next 8 are 20-cycle highs; then alternating 40/20 for 0xAA.
  - Each bit period is 63 cycles.
  - SEND lasts 3024 cycles, followed by 3000 low cycles, then a frame_done pulse.
- Bit timing: NUM_LEDS=1; pixel 0x800001 ->
  - Bit 23 high for 40 cycles; bits 22..1 high for 20 cycles each.
  - Bit 0 high for 40 cycles.
  - Rising edges exactly 63 cycles apart.
- Overrun: during SEND, pulse byte_valid with 0x55 ->
  - overrun=1 and stays 1.
  - Transmitted waveform unchanged.
  - Next frame loads correctly starting from pixel 0, byte G.
- Async reset mid-SEND: assert rst 500 cycles into SEND ->
  - dout=0 and busy=0 immediately, without waiting for a clock edge.
  - After release, 3*NUM_LEDS new bytes trigger a fresh full frame.
- Back-to-back frames: send frame A, wait for frame_done, send frame B ->
  - Second waveform reflects frame B only.
  - frame_done pulses exactly twice.
